// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter wrapped around one iterative shift-add multiplier.
// Requesters raise req and hold it until their done pulse. One requester is
// granted from IDLE, its operands are captured on the grant edge, and exactly
// WIDTH add/shift iterations run before a one-cycle done pulse returns the low
// WIDTH bits of the product.
module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic [ID_W-1:0]        owner,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]  pick;
  logic [ID_W-1:0]   pick_idx;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;

  // First set request found searching ptr+1, ptr+2, ... with wrap-around.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  ptr);
    logic [N_REQ-1:0] g;
    int               idx;
    g = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if ((g == '0) && r[ID_W'(idx)]) g[ID_W'(idx)] = 1'b1;
    end
    return g;
  endfunction

  // Index of the single set bit of a one-hot vector (0 when empty).
  function automatic logic [ID_W-1:0] onehot_idx(input logic [N_REQ-1:0] g);
    logic [ID_W-1:0] ix;
    ix = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g[ID_W'(i)]) ix = ID_W'(i);
    end
    return ix;
  endfunction

  // Arbitration only happens in IDLE; reset also forces the grant low.
  assign pick     = ((state == IDLE) && !rst) ? rr_pick(req, rr_ptr) : '0;
  assign pick_idx = onehot_idx(pick);

  // Route the granted requester's operands to the capture registers.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[ID_W'(i)]) begin
        sel_a = a_in[i*WIDTH +: WIDTH];
        sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // One shift-add step; wraps modulo 2^WIDTH so high product bits fall away.
  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed WIDTH-cycle RUN, no early exit on a zero multiplier.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick != '0) state_nxt = RUN;
      RUN:     if (last_iter)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: grant in IDLE, done to the owner in DONE, busy otherwise.
  always_comb begin
    gnt  = '0;
    done = '0;
    busy = 1'b0;
    unique case (state)
      IDLE: gnt = pick;
      RUN:  busy = 1'b1;
      DONE: begin
        busy        = 1'b1;
        done[owner] = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, iteration datapath, result, owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      owner  <= '0;
      rr_ptr <= ID_W'(N_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick != '0) begin
            mcand  <= sel_a;
            mplier <= sel_b;
            acc    <= '0;
            cnt    <= '0;
            owner  <= pick_idx;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) result <= acc_sum;
        end
        DONE: rr_ptr <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: a table of single-requester products
// followed by hand-written round-robin, fairness, reset and req-drop sequences.
module tb_mul_share_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic [1:0]     owner;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the grant-cycle negedge; returns cycles until done is seen.
  task automatic wait_done(output int lat, output int spur, output logic bok);
    lat  = 0;
    spur = 0;
    bok  = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done != '0) break;
      if (gnt != '0) spur++;
      if (!busy) bok = 1'b0;
    end
  endtask

  task automatic set_ops(input int id, input logic [63:0] a, input logic [63:0] b);
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
  endtask

  task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string tag);
    int   lat;
    int   spur;
    logic bok;
    @(posedge clk); #1;
    set_ops(id, a, b);
    req     = '0;
    req[id] = 1'b1;
    @(negedge clk);
    chk({tag, " gnt"}, gnt, 64'(1) << id);
    chk({tag, " idle busy"}, busy, 0);
    wait_done(lat, spur, bok);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " done"}, done, 64'(1) << id);
    chk({tag, " result"}, result, exp);
    chk({tag, " owner"}, owner, id);
    chk({tag, " spurious gnt"}, spur, 0);
    chk({tag, " busy in run"}, bok, 1);
    req[id] = 1'b0;
    @(negedge clk);
    chk({tag, " done cleared"}, done, 0);
    chk({tag, " busy cleared"}, busy, 0);
  endtask

  initial begin
    int   lat;
    int   spur;
    int   last_done;
    int   npulse;
    logic bok;

    vecs[0] = '{0, 64'd3, 64'd5, 64'd15};
    vecs[1] = '{1, 64'h8000_0000_0000_0000, 64'd2, 64'd0};
    vecs[2] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[3] = '{3, 64'd0, 64'd7, 64'd0};
    vecs[4] = '{0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
    vecs[5] = '{1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[6] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7] = '{3, 64'd12345, 64'd1000, 64'd12345000};

    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    #1;
    chk("reset gnt", gnt, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset owner", owner, 0);
    chk("reset busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // All four request at once: served 0,1,2,3 with a 66-cycle done period.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_ops(i, 64'(i + 2), 64'(10 * (i + 1)));
    req = 4'b1111;
    @(negedge clk);
    last_done = 0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rr gnt%0d", k), gnt, 64'(1) << k);
      wait_done(lat, spur, bok);
      chk($sformatf("rr lat%0d", k), lat, LAT);
      chk($sformatf("rr done%0d", k), done, 64'(1) << k);
      chk($sformatf("rr result%0d", k), result, 64'((k + 2) * 10 * (k + 1)));
      chk($sformatf("rr owner%0d", k), owner, k);
      chk($sformatf("rr spur%0d", k), spur, 0);
      if (k > 0) chk($sformatf("rr spacing%0d", k), cyc - last_done, LAT + 1);
      last_done = cyc;
      req[k] = 1'b0;
      @(negedge clk);
    end
    chk("rr idle gnt", gnt, 0);

    // Requester 1 re-requests right after its done while 2 waits: 2 goes first.
    @(posedge clk); #1;
    set_ops(1, 64'd6, 64'd7);
    set_ops(2, 64'd8, 64'd9);
    req = 4'b0110;
    @(negedge clk);
    chk("fair gnt1", gnt, 4'b0010);
    wait_done(lat, spur, bok);
    chk("fair done1", done, 4'b0010);
    chk("fair result1", result, 42);
    req[1] = 1'b0;
    @(posedge clk); #1;
    req[1] = 1'b1;
    @(negedge clk);
    chk("fair gnt2", gnt, 4'b0100);
    wait_done(lat, spur, bok);
    chk("fair done2", done, 4'b0100);
    chk("fair result2", result, 72);
    req[2] = 1'b0;
    @(negedge clk);
    chk("fair gnt1 again", gnt, 4'b0010);
    wait_done(lat, spur, bok);
    chk("fair done1 again", done, 4'b0010);
    chk("fair lat1 again", lat, LAT);
    req[1] = 1'b0;
    @(negedge clk);

    // Reset 10 cycles into RUN: immediate reset values, no done afterwards.
    @(posedge clk); #1;
    set_ops(3, 64'd11, 64'd13);
    req = 4'b1000;
    @(negedge clk);
    chk("rst gnt3", gnt, 4'b1000);
    repeat (10) @(negedge clk);
    chk("rst busy before", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst mid gnt", gnt, 0);
    chk("rst mid done", done, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid result", result, 0);
    chk("rst mid owner", owner, 0);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done != '0) npulse++;
    end
    chk("rst no done", npulse, 0);
    @(posedge clk); #1;
    set_ops(0, 64'd100, 64'd3);
    req = 4'b1001;
    @(negedge clk);
    chk("post-rst gnt0", gnt, 4'b0001);
    wait_done(lat, spur, bok);
    chk("post-rst lat", lat, LAT);
    chk("post-rst result0", result, 300);
    req[0] = 1'b0;
    @(negedge clk);
    chk("post-rst gnt3", gnt, 4'b1000);
    wait_done(lat, spur, bok);
    chk("post-rst result3", result, 143);
    req[3] = 1'b0;
    @(negedge clk);

    // Requester 2 drops req 5 cycles in; requester 0 arrives during RUN.
    @(posedge clk); #1;
    set_ops(2, 64'd7, 64'd9);
    req = 4'b0100;
    @(negedge clk);
    chk("drop gnt2", gnt, 4'b0100);
    repeat (5) @(negedge clk);
    req = 4'b0001;
    wait_done(lat, spur, bok);
    chk("drop lat", lat + 5, LAT);
    chk("drop spur", spur, 0);
    chk("drop done", done, 4'b0100);
    chk("drop result", result, 63);
    chk("drop owner", owner, 2);
    @(negedge clk);
    chk("drop next gnt0", gnt, 4'b0001);
    req = '0;
    @(negedge clk);
    chk("drop end busy", busy, 0);
    chk("drop end owner", owner, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Time-shares one iterative shift-add 64-bit multiplier among N_REQ requesters (add, sub and div units plus one spare port) using round-robin arbitration.
- Owns the req/gnt/done handshake, so the requesters no longer need to cross-acknowledge each other combinationally.
- Sits between the arithmetic units and the shared product bus. The product is the low WIDTH bits, the same truncation as the existing combinational multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand and result width in bits.
- ID_W, 2, width of the owner index; must equal clog2(N_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until that requester's done pulse.
- a_in  in  N_REQ*WIDTH  flattened multiplicands; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  in  N_REQ*WIDTH  flattened multipliers, same packing as a_in.
- gnt  out  N_REQ  one-hot grant; operands are captured on the clock edge where gnt[i]=1.
- done  out  N_REQ  one-cycle completion pulse to the owning requester.
- result  out  WIDTH  (a*b) mod 2^WIDTH; holds until the next completion.
- owner  out  ID_W  index of the current or last granted requester.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; gnt=0, done=0, result=0, owner=0, busy=0.
  - Internal acc, mcand, mplier and cnt cleared.
  - rr_ptr=N_REQ-1, so requester 0 has top priority first.
- FSM states IDLE, RUN, DONE; state is registered.
- IDLE:
  - gnt is decoded combinationally from req and rr_ptr: the first set req[i] searching rr_ptr+1, rr_ptr+2, … with wrap modulo N_REQ.
  - gnt=0 in every other state, and gnt=0 when req=0.
  - On an edge with gnt[i]=1: mcand←a_in[i], mplier←b_in[i], acc←0, cnt←0, owner←i, state→RUN.
- RUN, one iteration per cycle:
  - if mplier[0], acc←acc+mcand, modulo 2^WIDTH.
  - mcand←mcand<<1, dropping the MSB.
  - mplier←mplier>>1 (logical); cnt←cnt+1.
  - Exactly WIDTH iterations; no early exit on mplier==0. Fixed latency is required.
  - After the WIDTH-th iteration: result←final acc, state→DONE.
- DONE:
  - done[owner]=1 for exactly this one cycle; done=0 in all other states.
  - rr_ptr←owner; state→IDLE.
- Timing:
  - gnt in cycle T gives done in cycle T+WIDTH+1.
  - The earliest next gnt is T+WIDTH+2, so the back-to-back period is WIDTH+2.
- result changes only on the edge entering DONE. It is stable from the DONE cycle until the next DONE and must be sampled during the done pulse or later.
- Boundary conditions:
  - Requester drops req during RUN: no abort; the operation completes, done still pulses, result is updated.
  - Requester re-asserts req in the cycle after its done: it is serviced only after every other pending requester has been served once (round-robin fairness).
  - req changes in RUN or DONE are ignored; only IDLE arbitrates.
  - Operand inputs are don't-care except on the grant edge.
  - Reset asserted mid-RUN or mid-DONE: the operation is discarded, no done pulse is produced, and all outputs take their reset values immediately.
  - Zero operand: full latency, result=0.
  - Overflow: high product bits are silently discarded.
  - owner is stable from the grant edge through DONE and keeps its value while IDLE.
- Only unsigned multiplication is supported.

Test Plan:
- Reset, then req=0001, a0=3, b0=5 → gnt=0001 for 1 cycle; busy high; done=0001 exactly 65 cycles after gnt; result=15; owner=0.
- req=1111 held after reset, distinct operands, each req dropped after its done → grant order 0,1,2,3; done pulses spaced 66 cycles apart; each result matches its own operands.
- req[1] re-asserted immediately after its done while req[2] is pending → next grant goes to 2, then 1.
- a=2^63, b=2 → result=0; a=FFFF_FFFF_FFFF_FFFF, b=FFFF_FFFF_FFFF_FFFF → result=1; a=0, b=7 → result=0 with full 65-cycle latency.
- rst pulsed 10 cycles into RUN → outputs reset in the same cycle; no done pulse; the next request is serviced normally from requester 0 priority.
- req[2] dropped 5 cycles after its grant → done[2] still pulses at grant+65 with the correct product; no spurious grant occurs during RUN.
